onehot_scan_decoder: RTL

Registered, parametrised AW-to-2^AW one-hot decoder with a built-in sequencer. It is the successor to the fixed 2-to-4 and 4-to-16 structural decoders. Operating modes:
- Hold a host-loaded address.
- Auto-scan all select lines with a programmable dwell.
- Idle with all lines inactive.

It drives chip-select, row-select and LED/mux strobe fabrics that previously used the combinational decoders.

---
 rtl/decoder_pkg.sv | 19 +
 rtl/decoder_n_to_2n.sv | 19 +
 rtl/onehot_scan_decoder.sv | 118 +++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scanning one-hot decoder family.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    // Bit-slice form of the one-hot decode: bit idx of onehot(addr).
    function automatic logic onehot_bit(input logic [31:0] addr, input logic [31:0] idx);
        return addr == idx;
    endfunction

    function automatic logic apply_polarity(input logic active, input bit active_low);
        return active ^ active_low;
    endfunction

endpackage

// File: rtl/decoder_n_to_2n.sv
// Generalised combinational AW-to-2^AW decoder with enable.
module decoder_n_to_2n
    import decoder_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic [AW-1:0]      a,
    input  logic               e,
    output logic [(1<<AW)-1:0] y
);

    always_comb begin
        y = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            y[i] = e & onehot_bit(32'(a), 32'(i));
        end
    end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered one-hot select decoder with hold, auto-scan and idle modes.
module onehot_scan_decoder
    import decoder_pkg::*;
#(
    parameter int AW         = 4,
    parameter int DW         = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load_valid,
    input  logic [AW-1:0]      load_addr,
    output logic               load_ready,
    input  logic               scan_start,
    input  logic               scan_stop,
    input  logic [DW-1:0]      dwell,
    output logic [(1<<AW)-1:0] y,
    output logic [AW-1:0]      cur_addr,
    output logic               busy,
    output logic               wrap
);

    localparam int N = 1 << AW;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   dwell_reg_q, dwell_reg_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic            wrap_q, wrap_d;
    logic            busy_q, load_ready_q;
    logic [N-1:0]    y_act_q;
    logic [N-1:0]    dec_y;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        dwell_reg_d = dwell_reg_q;
        cnt_d       = cnt_q;
        wrap_d      = 1'b0;
        case (state_q)
            SCAN: begin
                if (scan_stop) begin
                    state_d = HOLD;
                end else if (scan_start) begin
                    addr_d      = '0;
                    dwell_reg_d = dwell;
                    cnt_d       = dwell;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d  = dwell_reg_q;
                    addr_d = addr_q + 1'b1;
                    wrap_d = (addr_q == {AW{1'b1}});
                end
            end
            IDLE, HOLD: begin
                // A start paired with a stop is cancelled outright, load included.
                if (scan_start && !scan_stop) begin
                    state_d     = SCAN;
                    addr_d      = '0;
                    dwell_reg_d = dwell;
                    cnt_d       = dwell;
                end else if (!scan_start && load_valid) begin
                    state_d = HOLD;
                    addr_d  = load_addr;
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

    // Decoding the next address lets y line up with cur_addr; en is folded in
    // here so it reaches y exactly one cycle after being sampled.
    decoder_n_to_2n #(.AW(AW)) u_dec (
        .a (addr_d),
        .e (en && (state_d != IDLE)),
        .y (dec_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            dwell_reg_q  <= '0;
            cnt_q        <= '0;
            wrap_q       <= 1'b0;
            busy_q       <= 1'b0;
            load_ready_q <= 1'b1;
            y_act_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            dwell_reg_q  <= dwell_reg_d;
            cnt_q        <= cnt_d;
            wrap_q       <= wrap_d;
            busy_q       <= (state_d == SCAN);
            load_ready_q <= (state_d != SCAN);
            y_act_q      <= dec_y;
        end
    end

    always_comb begin
        y = '0;
        for (int i = 0; i < N; i++) begin
            y[i] = apply_polarity(y_act_q[i], ACTIVE_LOW);
        end
    end

    assign cur_addr   = addr_q;
    assign busy       = busy_q;
    assign wrap       = wrap_q;
    assign load_ready = load_ready_q;

endmodule
